// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: per-channel programmable divisor, 50% duty divided clock and tick.
// Optional CLK_DIV_SYNC_EN adds a sync input that restarts all enabled channels in phase.
module clk_div_multi #(
  parameter int unsigned CH          = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CH-1:0]         en,
  input  logic [CH-1:0]         load,
  input  logic [CH*WIDTH-1:0]   div_in,
  output logic [CH-1:0]         div_clk,
  output logic [CH-1:0]         tick,
  output logic [CH-1:0]         upd_pend
`ifdef CLK_DIV_SYNC_EN
  ,
  input  logic                  sync
`endif
);

  logic [CH-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [CH-1:0][WIDTH-1:0] div_q, div_d;
  logic [CH-1:0][WIDTH-1:0] pend_q, pend_d;
  logic [CH-1:0]            clk_d, tick_d, upd_d;

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pend_d = pend_q;
    clk_d  = div_clk;
    tick_d = '0;
    upd_d  = upd_pend;
    for (int i = 0; i < CH; i++) begin
      if (!en[i]) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b1;
        upd_d[i] = 1'b0;
        if (load[i]) begin
          div_d[i] = div_in[i*WIDTH +: WIDTH];
        end else if (upd_pend[i]) begin
          div_d[i] = pend_q[i];
        end
`ifdef CLK_DIV_SYNC_EN
      end else if (sync) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b1;
        upd_d[i] = 1'b0;
        if (load[i]) begin
          div_d[i] = div_in[i*WIDTH +: WIDTH];
        end else if (upd_pend[i]) begin
          div_d[i] = pend_q[i];
        end
`endif
      end else if (cnt_q[i] == div_q[i]) begin
        // Half-period boundary: a load on this edge bypasses the pending slot.
        cnt_d[i]  = '0;
        clk_d[i]  = ~div_clk[i];
        tick_d[i] = 1'b1;
        upd_d[i]  = 1'b0;
        if (load[i]) begin
          div_d[i] = div_in[i*WIDTH +: WIDTH];
        end else if (upd_pend[i]) begin
          div_d[i] = pend_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        if (load[i]) begin
          pend_d[i] = div_in[i*WIDTH +: WIDTH];
          upd_d[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      div_q    <= {CH{WIDTH'(DEFAULT_DIV)}};
      pend_q   <= '0;
      div_clk  <= '1;
      tick     <= '0;
      upd_pend <= '0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      div_clk  <= clk_d;
      tick     <= tick_d;
      upd_pend <= upd_d;
    end
  end

endmodule
